bench_out_pager: RTL and testbench
==================================

Name: bench_out_pager

Overview:
- Parametrised successor to the 8-way benchmark output mux on the 8-pin tile I/O.
- Selects one of NUM_CH benchmark result channels, each CH_W bits wide, and pages it onto OUT_W output pins.
- Adds a latched selection, page stepping for channels wider than the pins, a freeze/snapshot mode and a sticky bad-select flag. The selection no longer tracks the live select pins.
- Sits between the benchmark instances and io_out in the top-level wrapper.

Parameters:
- NUM_CH, 8: number of result channels; must be 2 or more.
- CH_W, 16: width of each channel.
- OUT_W, 8: output pin width.
- Derived localparam SEL_W = clog2(NUM_CH).
- Derived localparam NUM_PG = ceil(CH_W/OUT_W).
- Derived localparam PG_W = max(1, clog2(NUM_PG)).

Ports:
- clk  in  1  system clock (tile io_in[6] at top level).
- reset_n  in  1  asynchronous active-low reset (tile io_in[7] at top level).
- ch_data  in  NUM_CH*CH_W  flattened channel data; channel k occupies bits [k*CH_W +: CH_W].
- sel_in  in  SEL_W  requested channel index.
- load  in  1  level input; a rising edge latches sel_in.
- page_step  in  1  level input; a rising edge advances the page.
- freeze  in  1  level input; high = hold a snapshot.
- out_data  out  OUT_W  registered output page.
- cur_sel  out  SEL_W  latched channel index.
- page_idx  out  PG_W  current page.
- frozen  out  1  high while in FROZEN state.
- sel_err  out  1  sticky flag: last load requested an out-of-range channel.

Behaviour:
- Reset (async, reset_n low):
  - out_data=0, cur_sel=0, page_idx=0, frozen=0, sel_err=0.
  - Edge-detect history registers = 0, so a level already high when reset releases counts as one rising edge.
  - State = LIVE.
- Edge detect:
  - load, page_step and freeze are each registered once.
  - rise = input & ~prev, one cycle wide, seen in the cycle after the pin goes high.
  - Inputs are assumed synchronous to clk; no synchroniser inside.
- States:
  - LIVE: the source word is ch_data[cur_sel].
  - FROZEN: the source word is the snapshot register.
  - LIVE->FROZEN on freeze rise; snapshot <= ch_data[cur_sel] in the same cycle.
  - FROZEN->LIVE when freeze is low (level); the change applies on the next clock.
- Load:
  - On load rise in LIVE with sel_in < NUM_CH: cur_sel <= sel_in, page_idx <= 0, sel_err <= 0.
  - On load rise with sel_in >= NUM_CH: cur_sel and page_idx unchanged, sel_err <= 1.
  - Load rise in FROZEN is ignored; no flag change.
- Page step:
  - On page_step rise, page_idx <= page_idx+1, wrapping to 0 after NUM_PG-1.
  - NUM_PG=1: page_idx stays 0.
  - Paging works in both states.
- Output:
  - out_data <= source[page_idx*OUT_W +: OUT_W]; bits beyond CH_W read 0 (last partial page is zero-padded).
  - Latency is 1 clk from any change of ch_data, cur_sel or page_idx to out_data.
  - A load or page rise therefore shows on out_data 2 cycles after the pin edge: 1 for edge detect, 1 for the output register.
- Simultaneous events, same cycle:
  - freeze rise + load rise: freeze wins, load is dropped, snapshot uses the old cur_sel.
  - load rise (accepted) + page_step rise: load wins, page_idx <= 0.
  - Rejected load + page_step rise: page advances normally.
- Reset mid-operation: all state clears immediately, including FROZEN and the snapshot.

Decomposition:
- Shared package bench_pkg:
  - state encoding: LIVE=1'b0, FROZEN=1'b1;
  - default NUM_CH/CH_W/OUT_W constants for the tile;
  - a clog2-based width helper function.
- One natural sub-module, rise_detect: 1-bit register plus AND-NOT, same clk/reset_n, instantiated three times.
- Page slicing and channel select stay inline.

Test Plan:
1. Reset with load, page_step and freeze low; ch_data ch0=16'hA55A -> out_data=8'h5A, cur_sel=0, page_idx=0, frozen=0, sel_err=0.
2. sel_in=3, pulse load, ch3=16'h1234 -> 2 clk later out_data=8'h34. Pulse page_step -> 8'h12. Pulse page_step again -> wraps to page 0, 8'h34.
3. On page 1 of ch3, sel_in=5, load and page_step rise together, ch5=16'hBEEF -> cur_sel=5, page_idx=0, out_data=8'hEF.
4. Channel 2 selected, ch2=16'h00C3; freeze rise, then ch2 changes to 16'hFFFF and load rises with sel_in=6 -> out_data stays 8'hC3, cur_sel stays 2. Drop freeze -> out_data=8'hFF within 2 clk.
5. NUM_CH=6, sel_in=7, pulse load -> sel_err=1, cur_sel unchanged. Then valid sel_in=1 load -> sel_err=0.
6. CH_W=12, OUT_W=8, ch0=12'hABC, step to page 1 -> out_data=8'h0A. Assert reset_n low mid-cycle while frozen -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bench_pkg.sv
// Shared types and defaults for the benchmark output pager.
// Width helper keeps 1-entry selectors at least one bit wide.
package bench_pkg;

    typedef enum logic {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } state_t;

    localparam int DEF_NUM_CH = 8;
    localparam int DEF_CH_W   = 16;
    localparam int DEF_OUT_W  = 8;

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// One-cycle rising-edge pulse from a synchronous level input.
// History clears on reset, so a level already high counts as an edge.
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= 1'b0;
        else          prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/bench_out_pager.sv
// Latched channel select and paging of benchmark results onto the
// tile output pins, with freeze snapshot and sticky bad-select flag.
module bench_out_pager
    import bench_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int CH_W   = DEF_CH_W,
    parameter  int OUT_W  = DEF_OUT_W,
    localparam int SEL_W  = width_of(NUM_CH),
    localparam int NUM_PG = (CH_W + OUT_W - 1) / OUT_W,
    localparam int PG_W   = width_of(NUM_PG)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_CH*CH_W-1:0] ch_data,
    input  logic [SEL_W-1:0]       sel_in,
    input  logic                   load,
    input  logic                   page_step,
    input  logic                   freeze,
    output logic [OUT_W-1:0]       out_data,
    output logic [SEL_W-1:0]       cur_sel,
    output logic [PG_W-1:0]        page_idx,
    output logic                   frozen,
    output logic                   sel_err
);

    state_t state_q, state_d;

    logic                    load_rise, step_rise, frz_rise;
    logic [CH_W-1:0]         snap_q, snap_d;
    logic [CH_W-1:0]         live_word, src;
    logic [NUM_PG*OUT_W-1:0] padded;
    logic [OUT_W-1:0]        out_d;
    logic [SEL_W-1:0]        sel_d;
    logic [PG_W-1:0]         page_d;
    logic                    err_d;
    logic                    load_take;

    rise_detect u_load (
        .clk(clk), .reset_n(reset_n), .level(load), .rise(load_rise)
    );
    rise_detect u_step (
        .clk(clk), .reset_n(reset_n), .level(page_step), .rise(step_rise)
    );
    rise_detect u_frz (
        .clk(clk), .reset_n(reset_n), .level(freeze), .rise(frz_rise)
    );

    always_comb begin
        live_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_sel == SEL_W'(k)) live_word = ch_data[k*CH_W +: CH_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        sel_d     = cur_sel;
        page_d    = page_idx;
        err_d     = sel_err;
        load_take = 1'b0;

        unique case (state_q)
            LIVE:   if (frz_rise) begin
                        state_d = FROZEN;
                        snap_d  = live_word;
                    end
            FROZEN: if (!freeze) state_d = LIVE;
            default: state_d = LIVE;
        endcase

        if (step_rise) begin
            if (page_idx == PG_W'(NUM_PG - 1)) page_d = '0;
            else                               page_d = page_idx + PG_W'(1);
        end

        // A freeze edge in the same cycle swallows the load entirely.
        load_take = load_rise && (state_q == LIVE) && !frz_rise;
        if (load_take) begin
            if (int'(sel_in) < NUM_CH) begin
                sel_d  = sel_in;
                page_d = '0;
                err_d  = 1'b0;
            end else begin
                err_d  = 1'b1;
            end
        end

        src    = (state_q == FROZEN) ? snap_q : live_word;
        padded = '0;
        padded[CH_W-1:0] = src;
        out_d  = padded[int'(page_idx)*OUT_W +: OUT_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LIVE;
            snap_q   <= '0;
            cur_sel  <= '0;
            page_idx <= '0;
            sel_err  <= 1'b0;
            out_data <= '0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            cur_sel  <= sel_d;
            page_idx <= page_d;
            sel_err  <= err_d;
            out_data <= out_d;
        end
    end

    assign frozen = (state_q == FROZEN);

endmodule

// File: tb/tb_bench_out_pager.sv
// Directed checks of the output pager: default 8x16->8 tile build
// and a 6x12->8 build for bad selects and the zero-padded last page.
module tb_bench_out_pager;

    logic         clk = 1'b0;
    logic         reset_n, reset_n2;

    logic [127:0] ch_data;
    logic [2:0]   sel_in;
    logic         load, page_step, freeze;
    logic [7:0]   out_data;
    logic [2:0]   cur_sel;
    logic [0:0]   page_idx;
    logic         frozen, sel_err;

    logic [71:0]  ch_data2;
    logic [2:0]   sel_in2;
    logic         load2, page_step2, freeze2;
    logic [7:0]   out_data2;
    logic [2:0]   cur_sel2;
    logic [0:0]   page_idx2;
    logic         frozen2, sel_err2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bench_out_pager dut (
        .clk(clk), .reset_n(reset_n), .ch_data(ch_data),
        .sel_in(sel_in), .load(load), .page_step(page_step),
        .freeze(freeze), .out_data(out_data), .cur_sel(cur_sel),
        .page_idx(page_idx), .frozen(frozen), .sel_err(sel_err)
    );

    bench_out_pager #(.NUM_CH(6), .CH_W(12), .OUT_W(8)) dut2 (
        .clk(clk), .reset_n(reset_n2), .ch_data(ch_data2),
        .sel_in(sel_in2), .load(load2), .page_step(page_step2),
        .freeze(freeze2), .out_data(out_data2), .cur_sel(cur_sel2),
        .page_idx(page_idx2), .frozen(frozen2), .sel_err(sel_err2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic l, input logic s);
        load = l; page_step = s;
        @(negedge clk);
        load = 1'b0; page_step = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse2(input logic l, input logic s);
        load2 = l; page_step2 = s;
        @(negedge clk);
        load2 = 1'b0; page_step2 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; reset_n2 = 1'b0;
        load = 0; page_step = 0; freeze = 0; sel_in = 0;
        load2 = 0; page_step2 = 0; freeze2 = 0; sel_in2 = 0;
        ch_data = '0;
        ch_data[0*16 +: 16] = 16'hA55A;
        ch_data[2*16 +: 16] = 16'h00C3;
        ch_data[3*16 +: 16] = 16'h1234;
        ch_data[5*16 +: 16] = 16'hBEEF;
        ch_data[6*16 +: 16] = 16'h6666;
        ch_data2 = '0;
        ch_data2[0*12 +: 12] = 12'hABC;
        ch_data2[1*12 +: 12] = 12'h123;

        tick(2);
        check("rst_out", out_data, 8'h00);
        check("rst_frozen", frozen, 1'b0);
        reset_n = 1'b1; reset_n2 = 1'b1;
        tick(2);
        check("t1_out", out_data, 8'h5A);
        check("t1_sel", cur_sel, 3'd0);
        check("t1_page", page_idx, 1'b0);
        check("t1_frozen", frozen, 1'b0);
        check("t1_err", sel_err, 1'b0);

        sel_in = 3'd3;
        pulse(1, 0);
        check("t2_load_out", out_data, 8'h34);
        check("t2_sel", cur_sel, 3'd3);
        pulse(0, 1);
        check("t2_page1_out", out_data, 8'h12);
        check("t2_page1_idx", page_idx, 1'b1);
        pulse(0, 1);
        check("t2_wrap_out", out_data, 8'h34);
        check("t2_wrap_idx", page_idx, 1'b0);

        pulse(0, 1);
        check("t3_pre_out", out_data, 8'h12);
        sel_in = 3'd5;
        pulse(1, 1);
        check("t3_sel", cur_sel, 3'd5);
        check("t3_page", page_idx, 1'b0);
        check("t3_out", out_data, 8'hEF);

        sel_in = 3'd2;
        pulse(1, 0);
        check("t4_live_out", out_data, 8'hC3);
        freeze = 1'b1;
        tick(1);
        check("t4_frozen", frozen, 1'b1);
        ch_data[2*16 +: 16] = 16'hFFFF;
        sel_in = 3'd6;
        pulse(1, 0);
        check("t4_hold_out", out_data, 8'hC3);
        check("t4_hold_sel", cur_sel, 3'd2);
        pulse(0, 1);
        check("t4_frz_page1", out_data, 8'h00);
        pulse(0, 1);
        check("t4_frz_page0", out_data, 8'hC3);
        freeze = 1'b0;
        tick(1);
        check("t4_unfrozen", frozen, 1'b0);
        tick(1);
        check("t4_live_again", out_data, 8'hFF);

        ch_data[2*16 +: 16] = 16'h00C3;
        tick(2);
        sel_in = 3'd3;
        freeze = 1'b1; load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(1);
        check("t4b_frozen", frozen, 1'b1);
        check("t4b_sel", cur_sel, 3'd2);
        check("t4b_out", out_data, 8'hC3);
        ch_data[2*16 +: 16] = 16'h5555;
        tick(1);
        check("t4b_snap", out_data, 8'hC3);
        freeze = 1'b0;
        tick(2);
        check("t4b_release", out_data, 8'h55);

        check("t5_init_out", out_data2, 8'hBC);
        sel_in2 = 3'd7;
        pulse2(1, 0);
        check("t5_err_set", sel_err2, 1'b1);
        check("t5_sel_keep", cur_sel2, 3'd0);
        sel_in2 = 3'd6;
        pulse2(1, 1);
        check("t5_rej_step_idx", page_idx2, 1'b1);
        check("t6_pad_out", out_data2, 8'h0A);
        sel_in2 = 3'd1;
        pulse2(1, 0);
        check("t5_err_clr", sel_err2, 1'b0);
        check("t5_sel1", cur_sel2, 3'd1);
        check("t5_sel1_out", out_data2, 8'h23);
        check("t5_sel1_page", page_idx2, 1'b0);

        sel_in2 = 3'd0;
        pulse2(1, 0);
        pulse2(0, 1);
        check("t6_page1_out", out_data2, 8'h0A);
        freeze2 = 1'b1;
        sel_in2 = 3'd7;
        tick(1);
        check("t6_frozen", frozen2, 1'b1);
        pulse2(1, 0);
        check("t6_frz_noerr", sel_err2, 1'b0);
        #2;
        reset_n2 = 1'b0;
        #1;
        check("t6_rst_out", out_data2, 8'h00);
        check("t6_rst_sel", cur_sel2, 3'd0);
        check("t6_rst_page", page_idx2, 1'b0);
        check("t6_rst_frozen", frozen2, 1'b0);
        check("t6_rst_err", sel_err2, 1'b0);
        freeze2 = 1'b0;
        tick(1);
        reset_n2 = 1'b1;
        tick(2);
        check("t6_post_out", out_data2, 8'hBC);
        check("t6_post_frozen", frozen2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
